full_subtractor: RTL and testbench
==================================

Name: full_subtractor

Overview:
1-bit full subtractor with a combinational difference/borrow core, plus a registered bit-serial wrapper.
- The wrapper chains the borrow across WIDTH consecutive bits (LSB first) to subtract multi-bit words.
- It sits in datapath test logic as the basic borrow-ripple cell and as a low-area serial subtractor.

Parameters:
WIDTH, 8, number of bits per serial word (must be at least 2).

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
a  input  1  minuend bit
b  input  1  subtrahend bit
c  input  1  borrow-in; used combinationally and for the first bit of a serial word
d  output  1  combinational difference
b0  output  1  combinational borrow-out
in_valid  input  1  qualifies a/b/c for the registered path
start  input  1  marks the first (LSB) bit of a serial word; sampled only when in_valid=1
d_q  output  1  registered difference
b0_q  output  1  registered borrow-out
out_valid  output  1  one-cycle strobe; d_q/b0_q are valid
word_done  output  1  high with out_valid on the last (MSB) bit of a serial word
busy  output  1  high while a serial word is in progress (state RUN)

Behaviour:
Interface: one clock; reset is asynchronous and active-high.

Combinational core:
- d = a ^ b ^ c; b0 = (~a & b) | (~a & c) | (b & c).
- Truth table as {a,b,c} -> {d,b0}: 000->00, 001->11, 010->11, 011->01, 100->10, 101->00, 110->00, 111->11.
- Zero latency. Independent of clk and rst; valid during reset.

Reset:
- d_q=0, b0_q=0, out_valid=0, word_done=0, busy=0.
- Internal borrow register=0, bit counter=0, state=IDLE.
- Reset mid-word aborts the word; no partial word_done.

Registered path, FSM states IDLE and RUN. Every accepted bit (in_valid=1) produces d_q/b0_q with out_valid=1 on the next rising edge (latency 1).
- in_valid=0: no output strobe; state, counter and borrow register hold (stall).
- IDLE, in_valid=1, start=0:
  - one-shot registered op using borrow-in c;
  - word_done=0; stays IDLE.
- IDLE, in_valid=1, start=1:
  - first bit, borrow-in = c;
  - borrow register <= b0 of this bit; counter <= 1; go to RUN; busy=1.
- RUN, in_valid=1, start=0:
  - borrow-in = borrow register, not c;
  - counter increments; borrow register <= new borrow.
  - When this is bit WIDTH: word_done=1 with out_valid, return to IDLE, counter <= 0.
- RUN, in_valid=1, start=1: restarts the word. This bit is treated as a new first bit using c; counter <= 1.
- b0_q on the word_done cycle is the final word borrow (1 means minuend < subtrahend).
- out_valid and word_done are single-cycle pulses unless the next bit is accepted back-to-back. Back-to-back acceptance at one bit per cycle is supported.

Optional Feature:
FULL_SUB_ZERO_FLAG_EN: adds output word_zero (1 bit).
- With the macro: word_zero is registered and asserted together with word_done when every d bit of the word was 0; it is low in all other cycles and reset to 0.
- An internal accumulator clears on each start-qualified bit.
- Without the macro: the port does not exist and there is no accumulator logic.

Test Plan:
- Combinational sweep: drive {a,b,c}=0..7, 5 ns each -> d/b0 match the truth table exactly (e.g. 011 -> d=0, b0=1; 100 -> d=1, b0=0).
- Serial word, WIDTH=8: 0x5A - 0x3C, LSB first, start on bit 0, c=0 -> d_q stream = 0x1E; final b0_q=0; word_done on the 8th out_valid only.
- Underflow: 0x10 - 0x20 -> d_q stream = 0xF0; b0_q=1 on the word_done cycle.
- Stall: same as the 0x5A case, with in_valid dropped for 3 cycles mid-word -> identical result; no out_valid during the gap; busy stays high.
- Reset mid-word: assert rst asynchronously after bit 4 -> all outputs 0 immediately and state IDLE; a following full word computes correctly.
- Zero flag (macro defined): 0x33 - 0x33 -> word_zero=1 with word_done. 0x34 - 0x33 -> word_zero=0.

Source files
------------

// File: rtl/full_subtractor.sv
// 1-bit full subtractor with a combinational core and a registered bit-serial wrapper.
// Optional macro FULL_SUB_ZERO_FLAG_EN adds the registered word_zero output.
module full_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic b0,
    input  logic in_valid,
    input  logic start,
    output logic d_q,
    output logic b0_q,
    output logic out_valid,
    output logic word_done,
`ifdef FULL_SUB_ZERO_FLAG_EN
    output logic word_zero,
`endif
    output logic busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              borrow_q;

    logic bin_acc;
    logic diff_acc;
    logic bout_acc;
    logic in_word;
    logic last_bit;

    assign d  = a ^ b ^ c;
    assign b0 = (~a & b) | (~a & c) | (b & c);

    assign busy = (state_q == StRun);

    always_comb begin
        // Continuing bits ripple the stored borrow; first bits and one-shots use c.
        in_word  = (state_q == StRun) && !start;
        bin_acc  = in_word ? borrow_q : c;
        diff_acc = a ^ b ^ bin_acc;
        bout_acc = (~a & b) | (~a & bin_acc) | (b & bin_acc);
        last_bit = in_word && (cnt_q == CntW'(WIDTH - 1));
    end

`ifdef FULL_SUB_ZERO_FLAG_EN
    logic zacc_q;
    logic zacc_d;

    always_comb begin
        zacc_d = start ? ~diff_acc : (zacc_q & ~diff_acc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zacc_q    <= 1'b0;
            word_zero <= 1'b0;
        end else if (in_valid) begin
            if (start || in_word) begin
                zacc_q <= zacc_d;
            end
            word_zero <= last_bit & zacc_d;
        end else begin
            word_zero <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            borrow_q  <= 1'b0;
            d_q       <= 1'b0;
            b0_q      <= 1'b0;
            out_valid <= 1'b0;
            word_done <= 1'b0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            d_q       <= diff_acc;
            b0_q      <= bout_acc;
            word_done <= last_bit;
            if (start) begin
                state_q  <= StRun;
                cnt_q    <= CntW'(1);
                borrow_q <= bout_acc;
            end else if (state_q == StRun) begin
                borrow_q <= bout_acc;
                if (last_bit) begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end else begin
            out_valid <= 1'b0;
            word_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_full_subtractor.sv
// Scoreboard bench for full_subtractor: combinational sweep plus serial words.
module tb_full_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0;
    logic in_valid = 1'b0, start = 1'b0;
    logic d, b0, d_q, b0_q, out_valid, word_done, busy;
    logic word_zero;

    int total = 0;
    int bad   = 0;

    // Expected per strobe: {d_q, b0_q, word_done, word_zero}
    logic [3:0] exp_q[$];

    full_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .b0        (b0),
        .in_valid  (in_valid),
        .start     (start),
        .d_q       (d_q),
        .b0_q      (b0_q),
        .out_valid (out_valid),
        .word_done (word_done),
`ifdef FULL_SUB_ZERO_FLAG_EN
        .word_zero (word_zero),
`endif
        .busy      (busy)
    );

`ifndef FULL_SUB_ZERO_FLAG_EN
    assign word_zero = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per output strobe.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 8'd1, 8'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("d_q", {7'd0, d_q}, {7'd0, e[3]});
                    chk("b0_q", {7'd0, b0_q}, {7'd0, e[2]});
                    chk("word_done", {7'd0, word_done}, {7'd0, e[1]});
`ifdef FULL_SUB_ZERO_FLAG_EN
                    chk("word_zero", {7'd0, word_zero}, {7'd0, e[0]});
`endif
                end
            end else if (!rst && word_done) begin
                chk("word_done_no_valid", 8'd1, 8'd0);
            end
        end
    end

    task automatic idle_cycle();
        in_valid = 1'b0;
        start    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Send an 8-bit word LSB first; stall_at >= 0 inserts a 3-cycle gap after that bit.
    // n_bits < 8 truncates the word (used for the reset-abort case).
    task automatic send_word(input logic [7:0] aw, input logic [7:0] bw,
                             input logic [7:0] exp_d, input logic exp_b,
                             input int stall_at, input int n_bits);
        int   bin;
        int   t;
        logic bo;
        logic last;
        bin = 0;
        for (int i = 0; i < n_bits; i++) begin
            t    = int'(aw[i]) - int'(bw[i]) - bin;
            bo   = (t < 0);
            bin  = bo ? 1 : 0;
            last = (i == 7);
            a        = aw[i];
            b        = bw[i];
            c        = 1'b0;
            start    = (i == 0);
            in_valid = 1'b1;
            exp_q.push_back({exp_d[i], last ? exp_b : bo, last, last && (exp_d == 8'h00)});
            @(posedge clk);
            #1;
            if (i == stall_at) begin
                in_valid = 1'b0;
                start    = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk);
                    #1;
                    chk("stall_no_valid", {7'd0, out_valid}, 8'd0);
                    chk("stall_busy", {7'd0, busy}, 8'd1);
                end
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    initial begin
        logic [1:0] tt[8];
        logic [2:0] v;
        tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

        // Combinational sweep while held in reset.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, c} = v;
            #5;
            chk("comb_sweep", {6'd0, d, b0}, {6'd0, tt[i]});
        end
        chk("rst_outputs", {3'd0, d_q, b0_q, out_valid, word_done, busy}, 8'd0);
        chk("rst_word_zero", {7'd0, word_zero}, 8'd0);

        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        // One-shot op in IDLE: 0 - 1 - 1 -> d=0, borrow=1.
        a = 1'b0; b = 1'b1; c = 1'b1; start = 1'b0; in_valid = 1'b1;
        exp_q.push_back(4'b0100);
        @(posedge clk);
        #1;
        chk("oneshot_busy", {7'd0, busy}, 8'd0);
        idle_cycle();
        chk("pulse_drops", {7'd0, out_valid}, 8'd0);

        send_word(8'h5A, 8'h3C, 8'h1E, 1'b0, -1, 8);
        chk("busy_after_word", {7'd0, busy}, 8'd1 - 8'd1);
        idle_cycle();
        chk("idle_after_word", {7'd0, busy}, 8'd0);

        send_word(8'h10, 8'h20, 8'hF0, 1'b1, -1, 8);
        idle_cycle();

        send_word(8'h5A, 8'h3C, 8'h1E, 1'b0, 3, 8);
        idle_cycle();

        // Abort mid-word with an asynchronous reset after four bits.
        send_word(8'h5A, 8'h3C, 8'h1E, 1'b0, -1, 4);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_outputs", {3'd0, d_q, b0_q, out_valid, word_done, busy}, 8'd0);
        chk("abort_word_zero", {7'd0, word_zero}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();
        send_word(8'h10, 8'h20, 8'hF0, 1'b1, -1, 8);
        idle_cycle();

        send_word(8'h33, 8'h33, 8'h00, 1'b0, -1, 8);
        idle_cycle();
        send_word(8'h34, 8'h33, 8'h01, 1'b0, -1, 8);

        repeat (4) idle_cycle();
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
